multi_cntdown_timer: RTL
========================

Name: multi_cntdown_timer

Overview:
N-channel successor to the single countdown timer core. It holds CH_NUM independent countdown channels, each with its own run state, preset memory, optional auto-reload mode and latched alarm. Debounced button pulses are steered to the channel selected by CH_SEL. The selected channel's remaining seconds feed the existing minutes/seconds BCD conversion and the display path.

Parameters:
CH_NUM, 4, number of independent channels (1..16)
CH_BITS, $clog2(CH_NUM) (minimum 1), width of CH_SEL
MAX_VAL, 60000, maximum count in seconds (1000 min)
BITS, $clog2(MAX_VAL+1), width of a channel count
ALARM_SECS, 10, number of RUN_CE ticks the alarm stays asserted before it auto-acknowledges

Ports:
CLK  in  1  system clock (100 MHz)
CLR_N  in  1  asynchronous, active-low reset
CE  in  1  clock enable for all state updates
RUN_CE  in  1  1 s tick, single-cycle pulse; honoured only when CE=1
CH_SEL  in  CH_BITS  channel targeted by the button inputs and shown on Q; values >= CH_NUM select nothing
BTN_RUN  in  1  start/pause/acknowledge pulse
BTN_MIN_INC, BTN_MIN_DEC  in  1  count +60 / -60 pulses
BTN_SEC_INC, BTN_SEC_DEC  in  1  count +1 / -1 pulses
RELOAD_EN  in  CH_NUM  per-channel auto-reload mode (static level)
Q  out  BITS  count of the selected channel; 0 if CH_SEL is out of range
IS_RUNNING  out  CH_NUM  channel is in state RUN
ALARM  out  CH_NUM  channel is in state EXPIRED
DONE_P  out  CH_NUM  one-cycle pulse whenever a channel's count reaches 0 (expiry or reload)

Behaviour:
- Reset (CLR_N=0): every channel goes to IDLE with count=0 and preset=0, and the alarm counter is cleared. Q=0, IS_RUNNING=0, ALARM=0, DONE_P=0. Reset is asynchronous; it takes effect immediately, including mid-countdown.
- Nothing changes on cycles with CE=0. Button pulses are one cycle wide and qualified by CE. Only the channel equal to CH_SEL sees the buttons.
- Per-channel states: IDLE, RUN, PAUSED, EXPIRED. All are registered; a button edge at cycle k is visible on the outputs at cycle k+1.
- Edits:
  - Accepted in IDLE and PAUSED only; ignored in RUN.
  - INC saturates at MAX_VAL and DEC clamps at 0 (e.g. 30 - 60 gives 0, MAX_VAL-10 + 60 gives MAX_VAL).
  - If more than one edit pulse is present in the same cycle, priority is MIN_INC > MIN_DEC > SEC_INC > SEC_DEC; only the winner applies.
- BTN_RUN transitions:
  - IDLE -> RUN if count != 0; preset := count. If count = 0, the press is ignored.
  - RUN -> PAUSED.
  - PAUSED -> RUN if count != 0, otherwise PAUSED -> IDLE. The preset is not updated on resume.
  - EXPIRED -> IDLE, acknowledging the alarm, with count := preset.
- Counting: in RUN, each RUN_CE decrements the count.
  - When the count goes 1 -> 0, DONE_P pulses.
  - If RELOAD_EN[i]=0: the channel moves to EXPIRED with count=0.
  - If RELOAD_EN[i]=1: count := preset on that same tick, the channel stays in RUN, and ALARM is not asserted.
- EXPIRED: ALARM is held high. The alarm counter increments on each RUN_CE. After ALARM_SECS ticks the channel auto-returns to IDLE with count := preset. Any edit pulse on the selected EXPIRED channel is treated as an acknowledge only (-> IDLE, count := preset); the edit itself is discarded.
- Simultaneous events:
  - BTN_RUN (pause) and RUN_CE on a RUN channel in the same cycle: the pause wins and the tick is dropped.
  - RUN_CE on expiry and a BTN_RUN in the same cycle: the expiry is processed first, so the channel enters EXPIRED and the press is ignored.
  - Unselected channels keep counting independently of CH_SEL.
- Changing CH_SEL affects only Q and button steering, never any channel's state. Q is a combinational mux of registered counts.
- Width rules: the minute step is the constant 60 at BITS width. Comparisons against MAX_VAL use BITS+1 bits to avoid overflow.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, EXPIRED=2'd3), the SECS_PER_MIN=60 constant, and the button-priority encoding.
- One sub-module, cntdown_channel: holds a single channel's state, count, preset, alarm counter and DONE_P. The top generates CH_NUM instances plus the CH_SEL decode and the Q mux.

Test Plan:
- Reset, then CH_SEL=0, SEC_INC x5, BTN_RUN, 5 RUN_CE ticks: Q steps 5,4,3,2,1,0; DONE_P[0] pulses once; ALARM[0]=1; after 10 further ticks ALARM[0]=0, state IDLE, Q=5.
- Channel 1 with RELOAD_EN[1]=1, preset 3, running 7 ticks: Q sequence 2,1,3,2,1,3,2; DONE_P[1] pulses twice; ALARM[1] stays 0.
- Saturation: MIN_INC x1001 gives Q=60000 (one more press leaves 60000). From 30, MIN_DEC gives 0. BTN_RUN at 0 leaves IS_RUNNING=0.
- Channel 0 running from 100 and channel 2 running from 50, CH_SEL switched to 2 after 10 ticks: Q=40; switching back shows Q=90. Edits on channel 2 while it runs are ignored.
- Same-cycle BTN_RUN and RUN_CE on a RUN channel at count 20: the channel enters PAUSED with Q=20. SEC_INC then gives 21, and a resume continues from 21.
- Drive CLR_N low asynchronously mid-countdown, between clock edges: all outputs 0 immediately. After release, every channel is IDLE and Q=0.

Source files
------------

// File: rtl/multi_cntdown_timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel states,
// the seconds-per-minute step and the edit-button priority encoder.
package multi_cntdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } chState_e;

  localparam int SECS_PER_MIN = 60;

  typedef enum logic [2:0] {
    EDIT_NONE    = 3'd0,
    EDIT_MIN_INC = 3'd1,
    EDIT_MIN_DEC = 3'd2,
    EDIT_SEC_INC = 3'd3,
    EDIT_SEC_DEC = 3'd4
  } edit_e;

  // Only one edit wins per cycle: MIN_INC > MIN_DEC > SEC_INC > SEC_DEC.
  function automatic edit_e editSelect(input logic minInc, input logic minDec,
                                       input logic secInc, input logic secDec);
    if (minInc) return EDIT_MIN_INC;
    if (minDec) return EDIT_MIN_DEC;
    if (secInc) return EDIT_SEC_INC;
    if (secDec) return EDIT_SEC_DEC;
    return EDIT_NONE;
  endfunction

endpackage

// File: rtl/cntdown_channel.sv
// One countdown channel: run state, count, preset, alarm hold counter and
// the registered DONE pulse.
module cntdown_channel
  import multi_cntdown_timer_pkg::*;
#(
  parameter int MAX_VAL    = 60000,
  parameter int BITS       = $clog2(MAX_VAL + 1),
  parameter int ALARM_SECS = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic            run_ce_i,
  input  logic            sel_i,
  input  logic            btn_run_i,
  input  logic            btn_min_inc_i,
  input  logic            btn_min_dec_i,
  input  logic            btn_sec_inc_i,
  input  logic            btn_sec_dec_i,
  input  logic            reload_en_i,
  output logic [BITS-1:0] count_o,
  output logic            running_o,
  output logic            alarm_o,
  output logic            done_p_o
);

  localparam int ABITS = $clog2(ALARM_SECS + 1);
  localparam logic [BITS:0] MaxW    = (BITS + 1)'(MAX_VAL);
  localparam logic [BITS:0] MinStep = {1'b0, BITS'(SECS_PER_MIN)};
  localparam logic [BITS:0] SecStep = (BITS + 1)'(1);

  chState_e         state_q, state_d;
  logic [BITS-1:0]  count_q, count_d, preset_q, preset_d, editVal;
  logic [ABITS-1:0] alarmCnt_q, alarmCnt_d;
  logic             done_q, done_d;
  logic             tick, runPress, anyEdit;
  edit_e            edit;
  logic [BITS:0]    wideCount, step, sum;

  assign tick      = ce_i & run_ce_i;
  assign runPress  = ce_i & sel_i & btn_run_i;
  assign edit      = (ce_i & sel_i) ? editSelect(btn_min_inc_i, btn_min_dec_i,
                                                 btn_sec_inc_i, btn_sec_dec_i)
                                    : EDIT_NONE;
  assign anyEdit   = (edit != EDIT_NONE);
  assign wideCount = {1'b0, count_q};
  assign step      = (edit == EDIT_MIN_INC || edit == EDIT_MIN_DEC) ? MinStep : SecStep;
  assign sum       = wideCount + step;

  // Arithmetic is one bit wider so saturation at MAX_VAL cannot overflow.
  always_comb begin
    editVal = count_q;
    case (edit)
      EDIT_MIN_INC, EDIT_SEC_INC: editVal = (sum > MaxW) ? MaxW[BITS-1:0] : BITS'(sum);
      EDIT_MIN_DEC, EDIT_SEC_DEC: editVal = (wideCount < step) ? '0 : BITS'(wideCount - step);
      default: editVal = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    preset_d   = preset_q;
    alarmCnt_d = alarmCnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (runPress) begin
          if (count_q != '0) begin
            state_d  = ST_RUN;
            preset_d = count_q;
          end
        end else if (anyEdit) begin
          count_d = editVal;
        end
      end
      ST_PAUSED: begin
        if (runPress) begin
          state_d = (count_q != '0) ? ST_RUN : ST_IDLE;
        end else if (anyEdit) begin
          count_d = editVal;
        end
      end
      ST_RUN: begin
        // Expiry beats a same-cycle press; otherwise a press beats the tick.
        if (tick && count_q == BITS'(1)) begin
          done_d = 1'b1;
          if (reload_en_i) begin
            count_d = preset_q;
          end else begin
            count_d    = '0;
            state_d    = ST_EXPIRED;
            alarmCnt_d = '0;
          end
        end else if (runPress) begin
          state_d = ST_PAUSED;
        end else if (tick && count_q != '0) begin
          count_d = count_q - BITS'(1);
        end
      end
      ST_EXPIRED: begin
        if (runPress || anyEdit) begin
          state_d    = ST_IDLE;
          count_d    = preset_q;
          alarmCnt_d = '0;
        end else if (tick) begin
          if (alarmCnt_q == ABITS'(ALARM_SECS - 1)) begin
            state_d    = ST_IDLE;
            count_d    = preset_q;
            alarmCnt_d = '0;
          end else begin
            alarmCnt_d = alarmCnt_q + ABITS'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      preset_q   <= '0;
      alarmCnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      preset_q   <= preset_d;
      alarmCnt_q <= alarmCnt_d;
      done_q     <= done_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = (state_q == ST_RUN);
  assign alarm_o   = (state_q == ST_EXPIRED);
  assign done_p_o  = done_q;

endmodule

// File: rtl/multi_cntdown_timer.sv
// CH_NUM independent countdown channels; buttons steer to the channel picked
// by CH_SEL, which also chooses the count shown on Q.
module multi_cntdown_timer
  import multi_cntdown_timer_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int CH_BITS    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  parameter int MAX_VAL    = 60000,
  parameter int BITS       = $clog2(MAX_VAL + 1),
  parameter int ALARM_SECS = 10
) (
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic               CE,
  input  logic               RUN_CE,
  input  logic [CH_BITS-1:0] CH_SEL,
  input  logic               BTN_RUN,
  input  logic               BTN_MIN_INC,
  input  logic               BTN_MIN_DEC,
  input  logic               BTN_SEC_INC,
  input  logic               BTN_SEC_DEC,
  input  logic [CH_NUM-1:0]  RELOAD_EN,
  output logic [BITS-1:0]    Q,
  output logic [CH_NUM-1:0]  IS_RUNNING,
  output logic [CH_NUM-1:0]  ALARM,
  output logic [CH_NUM-1:0]  DONE_P
);

  logic [BITS-1:0] chCount [CH_NUM];

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    cntdown_channel #(
      .MAX_VAL   (MAX_VAL),
      .BITS      (BITS),
      .ALARM_SECS(ALARM_SECS)
    ) u_ch (
      .clk_i        (CLK),
      .rst_ni       (CLR_N),
      .ce_i         (CE),
      .run_ce_i     (RUN_CE),
      .sel_i        (CH_SEL == CH_BITS'(i)),
      .btn_run_i    (BTN_RUN),
      .btn_min_inc_i(BTN_MIN_INC),
      .btn_min_dec_i(BTN_MIN_DEC),
      .btn_sec_inc_i(BTN_SEC_INC),
      .btn_sec_dec_i(BTN_SEC_DEC),
      .reload_en_i  (RELOAD_EN[i]),
      .count_o      (chCount[i]),
      .running_o    (IS_RUNNING[i]),
      .alarm_o      (ALARM[i]),
      .done_p_o     (DONE_P[i])
    );
  end

  // Out-of-range selections match no channel and leave Q at zero.
  always_comb begin
    Q = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (CH_SEL == CH_BITS'(i)) Q = chCount[i];
    end
  end

endmodule
